// File: rtl/lod_pkg.sv
// lod_pkg: shared definitions for the multi-lane leading-one detector.
//   pos_w(w)    : width of a bit index into a w-bit vector (at least 1)
//   lod_mode_e  : LOD_ONE detects the leading one, LOD_ZERO the leading zero
//   lod_res_t   : {found, pos} result of a single lane
package lod_pkg;

   localparam int POS_W_MAX = 6;

   function automatic int pos_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   typedef enum logic [0:0] {
      LOD_ONE  = 1'b0,
      LOD_ZERO = 1'b1
   } lod_mode_e;

   typedef struct packed {
      logic                 found;
      logic [POS_W_MAX-1:0] pos;
   } lod_res_t;

endpackage

// File: rtl/lod_seg_enc.sv
// lod_seg_enc: combinational priority encoder for an N-bit vector.
//   vec_i   : vector to search
//   found_o : vec_i is nonzero
//   pos_o   : index of the most significant set bit (0 when vec_i is zero)
module lod_seg_enc
   import lod_pkg::*;
#(
   parameter int N = 8,
   localparam int PW = pos_w(N)
) (
   input  logic [N-1:0]  vec_i,
   output logic          found_o,
   output logic [PW-1:0] pos_o
);

   // Ascending scan: the highest set bit is the last one to overwrite pos_o.
   always_comb begin
      found_o = |vec_i;
      pos_o   = '0;
      for (int i = 0; i < N; i++) begin
         pos_o = vec_i[i] ? PW'(i) : pos_o;
      end
   end

endmodule

// File: rtl/lod_pipe.sv
// lod_pipe: multi-lane pipelined leading-one detector with valid/ready flow.
//   clk, rst_n            : clock, asynchronous active-low reset
//   valid_in / ready_o    : upstream handshake (ready_o is combinational from ready_i)
//   mode_in               : 0 = leading one of data, 1 = leading one of ~data
//   data_in               : LANES lanes, lane k at [k*W +: W]
//   valid_out / ready_i   : downstream handshake
//   lod_pos, found        : per-lane MSB index of the operand and nonzero flag
//   norm_shift            : per-lane W-1-lod_pos, 0 when the operand is zero
module lod_pipe
   import lod_pkg::*;
#(
   parameter int W      = 32,
   parameter int LANES  = 4,
   parameter int STAGES = 2,
   parameter int SEG    = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          valid_in,
   output logic                          ready_o,
   input  logic                          mode_in,
   input  logic [LANES*W-1:0]            data_in,
   output logic                          valid_out,
   input  logic                          ready_i,
   output logic [LANES*pos_w(W)-1:0]     lod_pos,
   output logic [LANES-1:0]              found,
   output logic [LANES*pos_w(W)-1:0]     norm_shift
);

   localparam int PW  = pos_w(W);
   localparam int NST = (STAGES == 2) ? 2 : 1;

   if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
      $error("lod_pipe: STAGES must be 1 or 2");
   end

   logic [NST-1:0]       v_q, v_d;
   logic                 ld0_s, ld_last_s, last_in_valid_s;
   logic [LANES*W-1:0]   opnd_s;
   logic [LANES-1:0]     res_found_s;
   logic [LANES*PW-1:0]  res_pos_s;
   logic [LANES*PW-1:0]  shift_d;
   logic [LANES-1:0]     found_q;
   logic [LANES*PW-1:0]  pos_q, shift_q;

   // Last stage may load when empty or when downstream takes its beat.
   assign ld_last_s = !v_q[NST-1] || ready_i;

   // Per-lane mode inversion of the incoming beat.
   always_comb begin
      opnd_s = '0;
      for (int k = 0; k < LANES; k++) begin
         opnd_s[k*W +: W] = (mode_in == LOD_ZERO) ? ~data_in[k*W +: W] : data_in[k*W +: W];
      end
   end

   if (NST == 1) begin : g_one
      assign ld0_s           = ld_last_s;
      assign last_in_valid_s = valid_in;

      // Single stage: only the output register follows the input.
      always_comb begin
         v_d[0] = ld_last_s ? valid_in : v_q[0];
      end

      for (genvar k = 0; k < LANES; k++) begin : g_lane
         lod_seg_enc #(.N(W)) u_enc (
            .vec_i   (opnd_s[k*W +: W]),
            .found_o (res_found_s[k]),
            .pos_o   (res_pos_s[k*PW +: PW])
         );
      end
   end else begin : g_two
      localparam int NSEG = W / SEG;
      localparam int SPW  = pos_w(SEG);
      localparam int SIW  = pos_w(NSEG);

      logic [LANES*NSEG-1:0]     sf_d, sf_q;
      logic [LANES*NSEG*SPW-1:0] sp_d, sp_q;

      assign ld0_s           = !v_q[0] || ld_last_s;
      assign last_in_valid_s = v_q[0];

      // Two stages: each stage advances when it is allowed to load.
      always_comb begin
         v_d[0]     = ld0_s ? valid_in : v_q[0];
         v_d[NST-1] = ld_last_s ? v_q[0] : v_q[NST-1];
      end

      for (genvar k = 0; k < LANES; k++) begin : g_lane
         logic [SIW-1:0] seg_idx_s;
         logic [SPW-1:0] loc_pos_s;

         for (genvar g = 0; g < NSEG; g++) begin : g_seg
            lod_seg_enc #(.N(SEG)) u_enc (
               .vec_i   (opnd_s[k*W + g*SEG +: SEG]),
               .found_o (sf_d[k*NSEG + g]),
               .pos_o   (sp_d[(k*NSEG + g)*SPW +: SPW])
            );
         end

         // Highest segment holding a one; its found also is the lane found.
         lod_seg_enc #(.N(NSEG)) u_sel (
            .vec_i   (sf_q[k*NSEG +: NSEG]),
            .found_o (res_found_s[k]),
            .pos_o   (seg_idx_s)
         );

         // Absolute position = segment base + position inside the segment.
         always_comb begin
            loc_pos_s = sp_q[(k*NSEG + int'(seg_idx_s))*SPW +: SPW];
            res_pos_s[k*PW +: PW] = PW'(int'(seg_idx_s) * SEG + int'(loc_pos_s));
         end
      end

      // Stage-1 segment results; only real beats overwrite them.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sf_q <= '0;
            sp_q <= '0;
         end else if (ld0_s && valid_in) begin
            sf_q <= sf_d;
            sp_q <= sp_d;
         end
      end
   end

   // Normalisation shift, forced to zero for an all-zero operand.
   always_comb begin
      shift_d = '0;
      for (int k = 0; k < LANES; k++) begin
         shift_d[k*PW +: PW] = res_found_s[k] ? (PW'(W - 1) - res_pos_s[k*PW +: PW]) : '0;
      end
   end

   // Stage valid bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
      end else begin
         v_q <= v_d;
      end
   end

   // Output register; held while the downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         found_q <= '0;
         pos_q   <= '0;
         shift_q <= '0;
      end else if (ld_last_s && last_in_valid_s) begin
         found_q <= res_found_s;
         pos_q   <= res_pos_s;
         shift_q <= shift_d;
      end
   end

   assign ready_o    = ld0_s;
   assign valid_out  = v_q[NST-1];
   assign found      = found_q;
   assign lod_pos    = pos_q;
   assign norm_shift = shift_q;

endmodule

// File: tb/tb_lod_pipe.sv
module tb_lod_pipe;

   localparam int W  = 32;
   localparam int L  = 4;
   localparam int PW = 5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             valid_in2, valid_in1, mode_in, ready_i;
   logic [L*W-1:0]   data_in;
   logic             ready_o2, valid_out2, ready_o1, valid_out1;
   logic [L*PW-1:0]  lod_pos2, norm_shift2, lod_pos1, norm_shift1;
   logic [L-1:0]     found2, found1;

   typedef struct {
      logic [3:0]  f;
      logic [19:0] p;
      logic [19:0] s;
      int          cyc;
      bit          lat;
   } exp_t;

   exp_t q2[$];
   exp_t q1[$];
   int   out_cyc[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_fail = 0;
   bit   rand_rdy = 1'b0;
   bit   lat_mode = 1'b0;

   lod_pipe #(.W(32), .LANES(4), .STAGES(2), .SEG(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in2), .ready_o(ready_o2),
      .mode_in(mode_in), .data_in(data_in), .valid_out(valid_out2), .ready_i(ready_i),
      .lod_pos(lod_pos2), .found(found2), .norm_shift(norm_shift2)
   );

   lod_pipe #(.W(32), .LANES(4), .STAGES(1), .SEG(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in1), .ready_o(ready_o1),
      .mode_in(mode_in), .data_in(data_in), .valid_out(valid_out1), .ready_i(ready_i),
      .lod_pos(lod_pos1), .found(found1), .norm_shift(norm_shift1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] f, input int p0, input int p1, input int p2,
                               input int p3, input int s0, input int s1, input int s2, input int s3);
      exp_t e;
      e.f   = f;
      e.p   = {5'(p3), 5'(p2), 5'(p1), 5'(p0)};
      e.s   = {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
      e.cyc = 0;
      e.lat = 1'b0;
      return e;
   endfunction

   // Reference: scan each lane downward from the MSB.
   function automatic exp_t ref_model(input logic [L*W-1:0] d, input logic m);
      exp_t e;
      logic [W-1:0] lane;
      e = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < L; k++) begin
         lane = m ? ~d[k*W +: W] : d[k*W +: W];
         for (int b = W - 1; b >= 0; b--) begin
            if (lane[b] && !e.f[k]) begin
               e.f[k] = 1'b1;
               e.p[k*PW +: PW] = 5'(b);
               e.s[k*PW +: PW] = 5'(W - 1 - b);
            end
         end
      end
      return e;
   endfunction

   // Present one beat and hold it until accepted; push the expectation on acceptance.
   task automatic beat(input logic [L*W-1:0] d, input logic m, input exp_t e, input bit sel);
      bit acc = 1'b0;
      data_in = d;
      mode_in = m;
      if (sel) valid_in1 = 1'b1;
      else     valid_in2 = 1'b1;
      for (int n = 0; n < 100 && !acc; n++) begin
         @(negedge clk);
         if (sel ? ready_o1 : ready_o2) begin
            acc   = 1'b1;
            e.cyc = cyc;
            e.lat = lat_mode;
            if (sel) q1.push_back(e);
            else     q2.push_back(e);
         end
         @(posedge clk);
         #1;
      end
      chk("accept", acc, 64'(acc), 64'd1);
   endtask

   // Random downstream readiness while enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
      end
   end

   // Monitor for the 2-stage DUT: order, values, latency and stall stability.
   initial begin
      exp_t        e;
      logic [43:0] act, prev, expv;
      bit          prev_stall;
      prev_stall = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         act = {found2, lod_pos2, norm_shift2};
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall)
               chk("stall_hold", valid_out2 && (act == prev), {19'd0, valid_out2, act}, {19'd0, 1'b1, prev});
            if (valid_out2 && ready_i) begin
               out_cyc.push_back(cyc);
               if (q2.size() == 0) begin
                  chk("unexpected_out", 1'b0, 64'(act), 64'd0);
               end else begin
                  e = q2.pop_front();
                  expv = {e.f, e.p, e.s};
                  chk("beat2", act == expv, 64'(act), 64'(expv));
                  if (e.lat) chk("latency2", (cyc - e.cyc) == 2, 64'(cyc - e.cyc), 64'd2);
               end
            end
            prev_stall = valid_out2 && !ready_i;
            prev = act;
         end
      end
   end

   // Monitor for the 1-stage DUT.
   initial begin
      exp_t        e;
      logic [43:0] act, expv;
      forever begin
         @(negedge clk);
         act = {found1, lod_pos1, norm_shift1};
         if (rst_n && valid_out1 && ready_i) begin
            if (q1.size() == 0) begin
               chk("unexpected_out1", 1'b0, 64'(act), 64'd0);
            end else begin
               e = q1.pop_front();
               expv = {e.f, e.p, e.s};
               chk("beat1", act == expv, 64'(act), 64'(expv));
               if (e.lat) chk("latency1", (cyc - e.cyc) == 1, 64'(cyc - e.cyc), 64'd1);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [L*W-1:0] v1, v3, vs, d;
      exp_t e1, e2, e3, es;
      int   span;

      v1 = {32'h00010F00, 32'h00000000, 32'h00000001, 32'h80000000};
      v3 = {32'h7FFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFF0000};
      vs = {32'h00000000, 32'hFFFFFFFF, 32'h00000003, 32'h00400000};
      e1 = mk(4'b1011, 31, 0, 0, 16, 0, 31, 0, 15);
      e2 = mk(4'b1111, 30, 31, 31, 31, 1, 0, 0, 0);
      e3 = mk(4'b1101, 15, 0, 31, 31, 16, 0, 0, 0);
      es = mk(4'b0111, 22, 1, 31, 0, 9, 30, 0, 0);

      // Reset with valid_in held high.
      rst_n = 1'b0; valid_in2 = 1'b1; valid_in1 = 1'b0; mode_in = 1'b0; ready_i = 1'b1;
      data_in = {4{32'hDEADBEEF}};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_idle", !valid_out2 && found2 == 4'd0 && lod_pos2 == 20'd0 && norm_shift2 == 20'd0,
             {19'd0, valid_out2, found2, lod_pos2, norm_shift2}, 64'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("ready_after_reset", ready_o2 == 1'b1, 64'(ready_o2), 64'd1);

      // Directed vectors, back-to-back, latency checked.
      lat_mode = 1'b1;
      beat(v1, 1'b0, e1, 1'b0);
      beat(v1, 1'b1, e2, 1'b0);
      beat(v3, 1'b1, e3, 1'b0);
      valid_in2 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      lat_mode = 1'b0;

      // Backpressure: two beats fill the pipe, third waits.
      ready_i = 1'b0;
      beat(v1, 1'b0, e1, 1'b0);
      beat(v1, 1'b1, e2, 1'b0);
      fork
         beat(v3, 1'b1, e3, 1'b0);
         begin
            @(negedge clk);
            chk("ready_full", ready_o2 == 1'b0 && valid_out2 == 1'b1, {62'd0, ready_o2, valid_out2}, 64'd1);
            repeat (3) @(negedge clk);
            chk("ready_still_full", ready_o2 == 1'b0, 64'(ready_o2), 64'd0);
            @(posedge clk); #1;
            ready_i = 1'b1;
         end
      join
      valid_in2 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      span = -1;
      if (out_cyc.size() >= 3) span = out_cyc[out_cyc.size()-1] - out_cyc[out_cyc.size()-3];
      chk("drain_rate", span == 2, 64'(span), 64'd2);

      // Random beats with random downstream readiness.
      rand_rdy = 1'b1;
      for (int i = 0; i < 200; i++) begin
         for (int k = 0; k < L; k++) begin
            case ($urandom_range(0, 3))
               0:       d[k*W +: W] = 32'h0;
               1:       d[k*W +: W] = 32'hFFFFFFFF;
               default: d[k*W +: W] = 32'($urandom) >> $urandom_range(0, 31);
            endcase
         end
         mode_in = 1'($urandom_range(0, 1));
         beat(d, mode_in, ref_model(d, mode_in), 1'b0);
      end
      valid_in2 = 1'b0;
      rand_rdy = 1'b0;
      @(posedge clk); #2;
      ready_i = 1'b1;
      for (int i = 0; i < 50 && q2.size() != 0; i++) @(posedge clk);
      #1;
      chk("random_drained", q2.size() == 0, 64'(q2.size()), 64'd0);

      // Reset with two beats in flight.
      ready_i = 1'b0;
      beat(v1, 1'b0, e1, 1'b0);
      beat(v3, 1'b1, e3, 1'b0);
      valid_in2 = 1'b0;
      q2.delete();
      rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("flushed", !valid_out2 && ready_o2, {62'd0, valid_out2, ready_o2}, 64'd1);
      end
      @(posedge clk); #1;
      lat_mode = 1'b1;
      beat(v1, 1'b1, e2, 1'b0);
      valid_in2 = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Single-stage build.
      beat(vs, 1'b0, es, 1'b1);
      beat(v1, 1'b0, e1, 1'b1);
      valid_in1 = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      chk("q2_empty", q2.size() == 0, 64'(q2.size()), 64'd0);
      chk("q1_empty", q1.size() == 0, 64'(q1.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
